// File: rtl/util_axis_uart_rx_os.sv
// util_axis_uart_rx_os: oversampling UART receiver with an AXI-Stream master.
// Recovers start/data/parity/stop framing from rxd using the uart_ena
// oversample tick and presents each character with error flags in tuser
// ({overrun, framing, parity}).
// Optional build macro UTIL_AXIS_UART_RX_BREAK_DETECT_EN turns an all-zero
// frame into a one-cycle break_det pulse instead of a character.
module util_axis_uart_rx_os #(
  parameter int parity_ena  = 0,
  parameter int parity_type = 0,
  parameter int stop_bits   = 1,
  parameter int data_bits   = 8,
  parameter int oversample  = 16
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 uart_ena,
  input  logic                 rxd,
  output logic [data_bits-1:0] m_axis_tdata,
  output logic [2:0]           m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 break_det
);

  localparam int CNT_W = $clog2(oversample);
  // START samples on the oversample/2-th tick, counting the detection tick as 1.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(oversample / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(oversample - 1);
  localparam logic [2:0]       BIT_LAST = 3'(data_bits - 1);

`ifdef UTIL_AXIS_UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  logic [1:0]           sync_q, sync_d;
  logic                 rxs;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [data_bits-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 pbit_q, pbit_d;
  logic [data_bits-1:0] tdata_q, tdata_d;
  logic [2:0]           tuser_q, tuser_d;
  logic                 tvalid_q, tvalid_d;
  logic                 ovr_q, ovr_d;
  logic                 done;
  logic                 brk_fire;
  logic                 at_centre;
  logic                 stop_last;
  logic                 brk_cond;
  logic                 xfer;

  assign rxs = sync_q[1];

  // Receive framing: start qualification, bit-centre sampling, error capture.
  always_comb begin
    sync_d    = {sync_q[0], rxd};
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    pbit_d    = pbit_q;
    done      = 1'b0;
    brk_fire  = 1'b0;
    at_centre = (cnt_q == CNT_FULL);
    stop_last = (stop_bits < 2) || stop_q;
    // A break is judged at the first stop sample: everything seen so far was low.
    brk_cond  = BRK_EN && !stop_q && !rxs && (shreg_q == '0) &&
                ((parity_ena == 0) || !pbit_q);
    if (uart_ena) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            cnt_d   = CNT_W'(1);
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              cnt_d   = '0;
              bit_d   = 3'd0;
              stop_d  = 1'b0;
              shreg_d = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              pbit_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (at_centre) begin
            cnt_d   = '0;
            shreg_d = {rxs, shreg_q[data_bits-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
              state_d = (parity_ena != 0) ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (at_centre) begin
            cnt_d   = '0;
            pbit_d  = rxs;
            perr_d  = ((^shreg_q) ^ rxs) != (parity_type != 0);
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (at_centre) begin
            cnt_d = '0;
            if (brk_cond) begin
              brk_fire = 1'b1;
              state_d  = S_WAIT_HIGH;
            end else begin
              ferr_d = ferr_q | ~rxs;
              if (stop_last) begin
                done    = 1'b1;
                // After a bad stop the line may still be low; wait it out.
                state_d = (ferr_q | ~rxs) ? S_WAIT_HIGH : S_IDLE;
              end else begin
                stop_d = 1'b1;
              end
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Single-entry output register; a completion that finds it full is dropped.
  always_comb begin
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    ovr_d    = ovr_q;
    xfer     = tvalid_q && m_axis_tready;
    if (done) begin
      if (!tvalid_q || xfer) begin
        tdata_d  = shreg_q;
        tuser_d  = {ovr_q, ferr_d, perr_q};
        tvalid_d = 1'b1;
        ovr_d    = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      tvalid_d = 1'b0;
    end
  end

  // State registers; reset also discards any held output character.
  always_ff @(posedge aclk) begin
    if (arst) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      pbit_q   <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 3'b000;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      pbit_q   <= pbit_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;

`ifdef UTIL_AXIS_UART_RX_BREAK_DETECT_EN
  logic break_q;

  // Registered one-cycle break pulse.
  always_ff @(posedge aclk) begin
    if (arst) begin
      break_q <= 1'b0;
    end else begin
      break_q <= brk_fire;
    end
  end

  assign break_det = break_q;
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_util_axis_uart_rx_os.sv
// Bench for util_axis_uart_rx_os: 8N-odd-parity-1 frames at 16x oversample,
// uart_ena every 4 aclk. Stimulus pushes expected beats into a queue; a
// monitor pops and compares on every accepted output beat.
module tb_util_axis_uart_rx_os;

  localparam int BIT_CLKS = 64;

  logic       aclk = 1'b0;
  logic       arst = 1'b1;
  logic       uart_ena = 1'b0;
  logic       rxd = 1'b1;
  logic       tready = 1'b1;
  logic [7:0] tdata;
  logic [2:0] tuser;
  logic       tvalid;
  logic       break_det;

  logic [10:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int brk_seen = 0;
  int tdiv = 0;

  util_axis_uart_rx_os #(
    .parity_ena (1),
    .parity_type(1),
    .stop_bits  (1),
    .data_bits  (8),
    .oversample (16)
  ) dut (
    .aclk         (aclk),
    .arst         (arst),
    .uart_ena     (uart_ena),
    .rxd          (rxd),
    .m_axis_tdata (tdata),
    .m_axis_tuser (tuser),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .break_det    (break_det)
  );

  always #5 aclk = ~aclk;

  // Oversample tick: one aclk wide, every fourth cycle.
  always @(posedge aclk) begin
    if (tdiv == 3) begin
      tdiv     <= 0;
      uart_ena <= 1'b1;
    end else begin
      tdiv     <= tdiv + 1;
      uart_ena <= 1'b0;
    end
  end

  // Monitor: compare every accepted beat against the head of the queue.
  always begin
    @(negedge aclk);
    if (break_det) brk_seen++;
    if (!arst && tvalid && tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got tdata=%02h tuser=%03b, required no beat", tdata, tuser);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({tuser, tdata} !== e) begin
          bad++;
          $display("FAIL beat: got tdata=%02h tuser=%03b, required tdata=%02h tuser=%03b",
                   tdata, tuser, e[7:0], e[10:8]);
        end else begin
          $display("beat ok: tdata=%02h tuser=%03b", tdata, tuser);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_bits(input logic v, input int nbits);
    rxd = v;
    wait_clks(nbits * BIT_CLKS);
  endtask

  // Start, 8 data bits LSB first, parity, one stop, optional low tail, idle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stopv,
                            input int low_tail, input int idle_bits);
    send_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bits(d[i], 1);
    send_bits(p, 1);
    send_bits(stopv, 1);
    if (low_tail > 0) send_bits(1'b0, low_tail);
    send_bits(1'b1, idle_bits);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic [2:0] u);
    exp_q.push_back({u, d});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      wait_clks(1);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d beats outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", tag, got, req);
    end else begin
      $display("check ok: %s = %0h", tag, got);
    end
  endtask

  initial begin
    int brk_before;
    arst = 1'b1;
    wait_clks(5);
    check("reset_tvalid", 32'(tvalid), 32'd0);
    check("reset_tdata", 32'(tdata), 32'd0);
    check("reset_tuser", 32'(tuser), 32'd0);
    check("reset_break", 32'(break_det), 32'd0);
    arst = 1'b0;
    wait_clks(20);

    // Clean frame: 0x55 has four ones, odd parity bit = 1.
    expect_beat(8'h55, 3'b000);
    send_frame(8'h55, 1'b1, 1'b1, 0, 2);
    drain("clean");

    // Parity errors. 0xA3 = 1010_0011 has four ones, so parity bit 0 is wrong
    // under odd parity; 0xA7 has five ones, so parity bit 0 is correct.
    expect_beat(8'h55, 3'b001);
    send_frame(8'h55, 1'b0, 1'b1, 0, 2);
    expect_beat(8'hA3, 3'b001);
    send_frame(8'hA3, 1'b0, 1'b1, 0, 2);
    expect_beat(8'hA7, 3'b000);
    send_frame(8'hA7, 1'b0, 1'b1, 0, 2);
    drain("parity");

    // Framing error, line held low three more bit times afterwards.
    expect_beat(8'h0F, 3'b010);
    send_frame(8'h0F, 1'b1, 1'b0, 3, 2);
    drain("framing");

    // Glitch of 4 ticks is rejected; the next frame is clean.
    rxd = 1'b0;
    wait_clks(16);
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    expect_beat(8'h12, 3'b000);
    send_frame(8'h12, 1'b1, 1'b1, 0, 2);
    drain("glitch");

    // Overrun: 0x57 arrives while 0x56 is held, so it is lost and flagged on 0x58.
    tready = 1'b0;
    expect_beat(8'h56, 3'b000);
    send_frame(8'h56, 1'b1, 1'b1, 0, 2);
    send_frame(8'h57, 1'b0, 1'b1, 0, 2);
    check("held_tvalid", 32'(tvalid), 32'd1);
    check("held_tdata", 32'(tdata), 32'h56);
    tready = 1'b1;
    wait_clks(4);
    expect_beat(8'h58, 3'b100);
    send_frame(8'h58, 1'b0, 1'b1, 0, 2);
    drain("overrun");

    // Reset after data bit 3 of 0x99; the sender abandons that frame.
    send_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bits(1'(8'h99 >> i), 1);
    rxd = 1'b1;
    arst = 1'b1;
    wait_clks(1);
    arst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    check("after_reset_tvalid", 32'(tvalid), 32'd0);
    expect_beat(8'h3C, 3'b000);
    send_frame(8'h3C, 1'b1, 1'b1, 0, 2);
    drain("reset");

    // Break: line low for 12 bit times.
    brk_before = brk_seen;
`ifdef UTIL_AXIS_UART_RX_BREAK_DETECT_EN
    send_bits(1'b0, 12);
    send_bits(1'b1, 2);
    check("break_pulses", 32'(brk_seen - brk_before), 32'd1);
`else
    // All-zero data with parity bit 0 also fails odd parity, hence tuser 011.
    expect_beat(8'h00, 3'b011);
    send_bits(1'b0, 12);
    send_bits(1'b1, 2);
    drain("break_as_char");
    check("break_pulses", 32'(brk_seen - brk_before), 32'd0);
`endif
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
